// File: rtl/shift8_frame_ctrl.sv
// shift8_frame_ctrl
//   Turns a serial bit stream (MSB of each frame first) into WIDTH-bit words
//   and offers each completed word on a valid/ready port. It also detects
//   words lost because the consumer was still holding the previous one, and
//   partial frames that stall for too long.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   data_in carries a bit this cycle
//   data_in    serial bit, MSB of frame first
//   out_data   completed word, held until accepted
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data this cycle
//   busy       partial frame in progress
//   bit_count  bits received in the current frame
//   overrun    sticky flag: a completed word was dropped
//   frame_err  one-cycle pulse: partial frame dropped on timeout
//   err_clear  clears overrun (a same-cycle overrun takes priority)
module shift8_frame_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic                         data_in,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic [$clog2(WIDTH+1)-1:0]   bit_count,
   output logic                         overrun,
   output logic                         frame_err,
   input  logic                         err_clear
);

   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  FIRST_BIT = CNT_W'(1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    sreg;
   logic [IDLE_W-1:0]   idle_cnt;

   logic                complete;
   logic [WIDTH-1:0]    word;

   // The word is assembled from the incoming bit directly so it can be
   // captured on the same edge that samples the last bit.
   always_comb begin
      complete = in_valid && (state == RECV) && (bit_count == LAST_BIT);
      word     = {sreg[WIDTH-2:0], data_in};
   end

   assign busy = (state == RECV);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sreg      <= '0;
         out_data  <= '0;
         bit_count <= '0;
         idle_cnt  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;

         if (in_valid) begin
            sreg <= word;
         end

         case (state)
            IDLE: begin
               if (in_valid) begin
                  bit_count <= FIRST_BIT;
                  idle_cnt  <= '0;
                  state     <= RECV;
               end
            end
            RECV: begin
               if (in_valid) begin
                  idle_cnt <= '0;
                  if (bit_count == LAST_BIT) begin
                     bit_count <= '0;
                     state     <= IDLE;
                  end else begin
                     bit_count <= bit_count + 1'b1;
                  end
               end else if (idle_cnt == IDLE_LAST) begin
                  // Stalled too long: abandon the partial frame.
                  idle_cnt  <= '0;
                  bit_count <= '0;
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // A new word may replace one that is being accepted this same cycle,
         // which keeps out_valid high across back-to-back words.
         if (complete && (!out_valid || out_ready)) begin
            out_data  <= word;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (complete && out_valid && !out_ready) begin
            overrun <= 1'b1;
         end else if (err_clear) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift8_frame_ctrl.sv
// Testbench for shift8_frame_ctrl: a directed vector table, hand-written
// corner-case sequences, and a randomized run against a queue-based
// reference model.
module tb_shift8_frame_ctrl;

   localparam int W  = 8;
   localparam int TO = 16;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          data_in = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic [CW-1:0] bit_count;
   logic          overrun;
   logic          frame_err;
   logic          err_clear = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   shift8_frame_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .bit_count (bit_count),
      .overrun   (overrun),
      .frame_err (frame_err),
      .err_clear (err_clear)
   );

   always #5 clk = ~clk;

   // Reference model: bits of the current frame kept in a queue, an idle-gap
   // counter, and the word currently offered to the consumer.
   bit         m_q[$];
   int         m_idle = 0;
   logic [W-1:0] m_data = '0;
   logic       m_valid = 1'b0;
   logic       m_ovr = 1'b0;
   logic       m_fe = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, iv, d, rdy, clr);
      logic         done;
      logic         ovr_set;
      logic [W-1:0] w;
      done = 1'b0;
      ovr_set = 1'b0;
      w = '0;
      if (r) begin
         m_q.delete();
         m_idle  = 0;
         m_data  = '0;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         m_fe    = 1'b0;
      end else begin
         m_fe = 1'b0;
         if (iv) begin
            m_q.push_back(d);
            m_idle = 0;
            if (m_q.size() == W) begin
               for (int i = 0; i < W; i++) w = W'((w << 1) | W'(m_q[i]));
               m_q.delete();
               done = 1'b1;
            end
         end else if (m_q.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
               m_q.delete();
               m_idle = 0;
               m_fe = 1'b1;
            end
         end
         if (done) begin
            if (!m_valid || rdy) begin
               m_data  = w;
               m_valid = 1'b1;
            end else begin
               ovr_set = 1'b1;
            end
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
         end
         if (ovr_set) m_ovr = 1'b1;
         else if (clr) m_ovr = 1'b0;
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare just after.
   task automatic step(input logic r, iv, d, rdy, clr);
      reset     = r;
      in_valid  = iv;
      data_in   = d;
      out_ready = rdy;
      err_clear = clr;
      @(posedge clk);
      model_update(r, iv, d, rdy, clr);
      #1;
      chk("model out_data",  32'(out_data),  32'(m_data));
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      chk("model bit_count", 32'(bit_count), 32'(m_q.size()));
      chk("model busy",      32'(busy),      32'(m_q.size() > 0));
      chk("model overrun",   32'(overrun),   32'(m_ovr));
      chk("model frame_err", 32'(frame_err), 32'(m_fe));
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic rdy_other, input logic rdy_last);
      for (int i = W - 1; i >= 0; i--)
         step(1'b0, 1'b1, w[i], (i == 0) ? rdy_last : rdy_other, 1'b0);
   endtask

   typedef struct {
      logic          rst, iv, d, rdy, clr;
      logic          ev;
      logic [W-1:0]  ed;
      logic [CW-1:0] ebc;
      logic          ebusy, eovr, efe;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe_seen;
      int fe_at;
      int gap;
      logic iv_r;

      // Frame 0,1,1,1,0,1,0,1 -> 8'h75, then accepted.
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd2, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd5, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd6, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd7, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h75, 4'd0, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h75, 4'd0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         chk("tbl out_valid", 32'(out_valid), 32'(tbl[i].ev));
         chk("tbl out_data",  32'(out_data),  32'(tbl[i].ed));
         chk("tbl bit_count", 32'(bit_count), 32'(tbl[i].ebc));
         chk("tbl busy",      32'(busy),      32'(tbl[i].ebusy));
         chk("tbl overrun",   32'(overrun),   32'(tbl[i].eovr));
         chk("tbl frame_err", 32'(frame_err), 32'(tbl[i].efe));
      end

      // Overrun: second word dropped while the first is held.
      send_word(8'hA5, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b0);
      chk("ovr held data", 32'(out_data), 32'h0A5);
      chk("ovr flag", 32'(overrun), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr cleared", 32'(overrun), 32'd0);
      idle(1'b1);
      chk("ovr drained valid", 32'(out_valid), 32'd0);

      // Back-to-back: 0F accepted on the edge where F0 completes.
      send_word(8'h0F, 1'b0, 1'b0);
      for (int i = W - 1; i >= 0; i--) begin
         step(1'b0, 1'b1, W'(8'hF0) >> i, (i == 0), 1'b0);
         chk("b2b valid held", 32'(out_valid), 32'd1);
      end
      chk("b2b data", 32'(out_data), 32'h0F0);
      chk("b2b overrun", 32'(overrun), 32'd0);
      idle(1'b1);

      // Timeout after 3 bits and 16 idle cycles.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      fe_seen = 0;
      fe_at = 0;
      for (int i = 1; i <= TO + 1; i++) begin
         idle(1'b0);
         if (frame_err) begin
            fe_seen++;
            fe_at = i;
            chk("timeout bit_count", 32'(bit_count), 32'd0);
         end
      end
      chk("timeout pulses", 32'(fe_seen), 32'd1);
      chk("timeout cycle", 32'(fe_at), 32'(TO));
      send_word(8'h81, 1'b0, 1'b0);
      chk("after timeout data", 32'(out_data), 32'h081);
      idle(1'b1);

      // Gaps one short of the timeout never drop the frame.
      fe_seen = 0;
      for (int i = W - 1; i >= 0; i--) begin
         step(1'b0, 1'b1, W'(8'hC3) >> i, 1'b0, 1'b0);
         if (i >= W - 5) begin
            for (int g = 0; g < TO - 1; g++) begin
               idle(1'b0);
               if (frame_err) fe_seen++;
            end
         end
      end
      chk("gap no frame_err", 32'(fe_seen), 32'd0);
      chk("gap data", 32'(out_data), 32'h0C3);
      idle(1'b1);

      // Reset mid-frame.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i[0], 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst data", 32'(out_data), 32'd0);
      chk("rst valid", 32'(out_valid), 32'd0);
      chk("rst bit_count", 32'(bit_count), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst frame_err", 32'(frame_err), 32'd0);
      send_word(8'h5A, 1'b0, 1'b0);
      chk("post rst data", 32'(out_data), 32'h05A);

      // Randomized traffic with occasional long gaps, clears and resets.
      gap = 0;
      for (int c = 0; c < 3000; c++) begin
         if (gap == 0 && $urandom_range(0, 99) < 3) gap = $urandom_range(10, 20);
         if (gap > 0) begin
            iv_r = 1'b0;
            gap--;
         end else begin
            iv_r = ($urandom_range(0, 3) != 0);
         end
         step(($urandom_range(0, 499) == 0), iv_r, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
